// File: rtl/msg_schedule_if.sv
// AXI-Stream style word channel used on both sides of msg_schedule.
interface msg_schedule_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/msg_schedule.sv
// SHA-2 message schedule: 16 loaded words in, W_0..W_{N-1} out, one per HCU round.
// Define MSG_SCHEDULE_SHA512_EN to build the 64-bit (SHA-384/512) datapath.
module msg_schedule (
    input  logic           axi_aclk,
    input  logic           reset,
    input  logic [1:0]     sha_type,
    msg_schedule_if.slave  s_axis,
    msg_schedule_if.master m_axis
);
    localparam int unsigned DATA_WIDTH = 64;

    typedef enum logic {StLoad, StExpand} state_e;

    state_e                state_q, state_d;
    logic [6:0]            t_q, t_d;
    logic [DATA_WIDTH-1:0] win_q [16];
    logic [DATA_WIDTH-1:0] win_d [16];
    logic                  mode64_q, mode64_d;
    logic                  blk_last_q, blk_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;

    logic                  ofree, in_ready, cur_mode;
    logic [6:0]            t_final;
    logic [DATA_WIDTH-1:0] in_word, w_new;
    logic [31:0]           w32;
    logic                  unused_in;

    function automatic logic [31:0] sig0_32(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1_32(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign w32 = sig1_32(win_q[14][63:32]) + win_q[9][63:32]
               + sig0_32(win_q[1][63:32]) + win_q[0][63:32];

`ifdef MSG_SCHEDULE_SHA512_EN
    logic [63:0] w64;

    function automatic logic [63:0] sig0_64(input logic [63:0] x);
        return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
    endfunction

    function automatic logic [63:0] sig1_64(input logic [63:0] x);
        return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
    endfunction

    assign w64      = sig1_64(win_q[14]) + win_q[9] + sig0_64(win_q[1]) + win_q[0];
    assign w_new    = mode64_q ? w64 : {w32, 32'h0};
    // The t=0 word is formatted with the mode being latched alongside it.
    assign cur_mode = (t_q == 7'd0) ? sha_type[1] : mode64_q;
`else
    assign w_new    = {w32, 32'h0};
    assign cur_mode = 1'b0;
`endif

    assign unused_in = ^{sha_type, s_axis.tdata[31:0]};

    assign t_final  = mode64_q ? 7'd79 : 7'd63;
    assign in_word  = cur_mode ? s_axis.tdata : {s_axis.tdata[63:32], 32'h0};
    assign ofree    = !out_valid_q || m_axis.tready;
    assign in_ready = (state_q == StLoad) && ofree && !reset;

    assign s_axis.tready = in_ready;
    assign m_axis.tdata  = out_data_q;
    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tlast  = out_last_q;

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        win_d       = win_q;
        mode64_d    = mode64_q;
        blk_last_d  = blk_last_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !m_axis.tready;
        out_last_d  = out_valid_d && out_last_q;
        unique case (state_q)
            StLoad: begin
                if (s_axis.tvalid && in_ready) begin
                    out_data_d  = in_word;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
                    win_d[15] = in_word;
                    t_d       = t_q + 7'd1;
                    if (t_q == 7'd0) mode64_d = cur_mode;
                    if (t_q == 7'd15) begin
                        blk_last_d = s_axis.tlast;
                        state_d    = StExpand;
                    end
                end
            end
            StExpand: begin
                if (ofree) begin
                    out_data_d  = w_new;
                    out_valid_d = 1'b1;
                    out_last_d  = blk_last_q && (t_q == t_final);
                    for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
                    win_d[15] = w_new;
                    if (t_q == t_final) begin
                        t_d     = 7'd0;
                        state_d = StLoad;
                    end else begin
                        t_d = t_q + 7'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state_q     <= StLoad;
            t_q         <= 7'd0;
            mode64_q    <= 1'b0;
            blk_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            mode64_q    <= mode64_d;
            blk_last_q  <= blk_last_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            win_q       <= win_d;
        end
    end
endmodule

// File: tb/tb_msg_schedule.sv
// Self-checking bench for msg_schedule: directed SHA-2 "abc" blocks and corner sequences.
module tb_msg_schedule;
    logic       axi_aclk = 1'b0;
    logic       reset;
    logic [1:0] sha_type;

    msg_schedule_if s_if ();
    msg_schedule_if m_if ();

    msg_schedule dut (
        .axi_aclk (axi_aclk),
        .reset    (reset),
        .sha_type (sha_type),
        .s_axis   (s_if.slave),
        .m_axis   (m_if.master)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        string       name;
        int          beat;
        logic [63:0] data;
        logic        last;
    } vec_t;

    vec_t        v256 [5];
    vec_t        v512 [2];
    int          n_cmp;
    int          n_err;
    int          cyc;
    int          acc0;
    logic [63:0] src_d [$];
    logic        src_l [$];
    logic [63:0] got_d [$];
    logic        got_l [$];
    int          got_cyc [$];
    logic [63:0] blk_w [16];
    logic [63:0] exp_w [80];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r32(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [63:0] r64(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    // Reference schedule, recurrence written directly in terms of W_{t-k}.
    task automatic build(input bit m64, input int n);
        logic [31:0] a, b, s0, s1;
        logic [63:0] a6, b6, s06, s16;
        for (int t = 0; t < 16; t++) exp_w[t] = m64 ? blk_w[t] : {blk_w[t][63:32], 32'h0};
        for (int t = 16; t < n; t++) begin
            if (m64) begin
                a6  = exp_w[t-15];
                b6  = exp_w[t-2];
                s06 = r64(a6, 1) ^ r64(a6, 8) ^ (a6 >> 7);
                s16 = r64(b6, 19) ^ r64(b6, 61) ^ (b6 >> 6);
                exp_w[t] = s16 + exp_w[t-7] + s06 + exp_w[t-16];
            end else begin
                a  = exp_w[t-15][63:32];
                b  = exp_w[t-2][63:32];
                s0 = r32(a, 7) ^ r32(a, 18) ^ (a >> 3);
                s1 = r32(b, 17) ^ r32(b, 19) ^ (b >> 10);
                exp_w[t] = {s1 + exp_w[t-7][63:32] + s0 + exp_w[t-16][63:32], 32'h0};
            end
        end
    endtask

    task automatic set_abc256();
        for (int i = 0; i < 16; i++) blk_w[i] = 64'h0;
        blk_w[0]  = 64'h61626380_00000000;
        blk_w[15] = 64'h00000018_00000000;
    endtask

    task automatic set_blk2();
        for (int i = 0; i < 16; i++) blk_w[i] = {32'(32'h9E3779B9 * (i + 1)), 32'h0};
    endtask

    // 32-bit blocks carry junk in [31:0], which must be ignored.
    task automatic push_blk(input bit last, input bit m64);
        for (int i = 0; i < 16; i++) begin
            src_d.push_back(m64 ? blk_w[i] : {blk_w[i][63:32], 32'hA5A5_5A5A ^ 32'(i)});
            src_l.push_back(last && (i == 15));
        end
    endtask

    task automatic run(input int n_beats, input bit bp, input logic [1:0] st_first,
                       input logic [1:0] st_rest, input int budget);
        int          k;
        int          idx;
        bit          was_stall;
        logic [63:0] held_d;
        logic        held_l;
        k = 0;
        idx = 0;
        was_stall = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        got_d.delete();
        got_l.delete();
        got_cyc.delete();
        sha_type = st_first;
        while (got_d.size() < n_beats && k < budget) begin
            @(negedge axi_aclk);
            if (idx > 0) sha_type = st_rest;
            s_if.tvalid = idx < src_d.size();
            s_if.tdata  = (idx < src_d.size()) ? src_d[idx] : 64'h0;
            s_if.tlast  = (idx < src_d.size()) ? src_l[idx] : 1'b0;
            m_if.tready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            #1;
            if (was_stall) begin
                check("stall_hold_data", m_if.tdata, held_d);
                check("stall_hold_last", 64'(m_if.tlast), 64'(held_l));
            end
            was_stall = m_if.tvalid && !m_if.tready;
            if (was_stall) begin
                held_d = m_if.tdata;
                held_l = m_if.tlast;
                check("stall_s_tready", 64'(s_if.tready), 64'd0);
            end
            if (m_if.tvalid && m_if.tready) begin
                got_d.push_back(m_if.tdata);
                got_l.push_back(m_if.tlast);
                got_cyc.push_back(cyc);
            end
            if (s_if.tvalid && s_if.tready) begin
                if (idx == 0) acc0 = cyc;
                idx++;
            end
            k++;
            cyc++;
        end
        if (got_d.size() < n_beats) begin
            n_cmp++;
            n_err++;
            $display("FAIL run_timeout: got %0d beats expected %0d", got_d.size(), n_beats);
        end
        @(negedge axi_aclk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        src_d.delete();
        src_l.delete();
    endtask

    task automatic check_model(input string tag, input int offs, input int n, input bit blast);
        for (int t = 0; t < n; t++) begin
            if (offs + t >= got_d.size()) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s_missing: got %0d beats expected %0d", tag, got_d.size(),
                         offs + n);
                break;
            end
            check($sformatf("%s_w%0d", tag, t), got_d[offs+t], exp_w[t]);
            check($sformatf("%s_last%0d", tag, t), 64'(got_l[offs+t]),
                  64'(blast && (t == n - 1)));
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        if (v.beat >= got_d.size()) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_%s: got %0d beats expected >%0d", tag, v.name, got_d.size(),
                     v.beat);
        end else begin
            check({tag, "_", v.name}, got_d[v.beat], v.data);
            check({tag, "_", v.name, "_last"}, 64'(got_l[v.beat]), 64'(v.last));
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_s_tready"}, 64'(s_if.tready), 64'd0);
        check({tag, "_m_tvalid"}, 64'(m_if.tvalid), 64'd0);
        check({tag, "_m_tdata"}, m_if.tdata, 64'd0);
        check({tag, "_m_tlast"}, 64'(m_if.tlast), 64'd0);
    endtask

    initial begin
        v256[0] = '{"w0",  0,  64'h61626380_00000000, 1'b0};
        v256[1] = '{"w15", 15, 64'h00000018_00000000, 1'b0};
        v256[2] = '{"w16", 16, 64'h61626380_00000000, 1'b0};
        v256[3] = '{"w17", 17, 64'h000F0000_00000000, 1'b0};
        v256[4] = '{"w63", 63, 64'h12B1EDEB_00000000, 1'b1};
        v512[0] = '{"w16", 16, 64'h61626380_00000000, 1'b0};
        v512[1] = '{"w17", 17, 64'h00030000_000000C0, 1'b0};

        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        acc0 = 0;
        reset = 1'b1;
        sha_type = 2'd0;
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        s_if.tlast = 1'b0;
        m_if.tready = 1'b1;
        repeat (3) @(negedge axi_aclk);
        #1;
        reset_checks("por");
        @(negedge axi_aclk);
        reset = 1'b0;
        #1;
        check("first_cycle_s_tready", 64'(s_if.tready), 64'd1);

        // SHA-256 "abc"
        set_abc256();
        push_blk(1'b1, 1'b0);
        run(64, 1'b0, 2'd0, 2'd0, 300);
        check("latency", 64'(got_cyc.size() > 0 ? got_cyc[0] : -1), 64'(acc0 + 1));
        build(1'b0, 64);
        check_model("abc256", 0, 64, 1'b1);
        for (int i = 0; i < 5; i++) check_vec("abc256", v256[i]);

`ifdef MSG_SCHEDULE_SHA512_EN
        // SHA-512 "abc"
        for (int i = 0; i < 16; i++) blk_w[i] = 64'h0;
        blk_w[0]  = 64'h61626380_00000000;
        blk_w[15] = 64'h00000000_00000018;
        push_blk(1'b1, 1'b1);
        run(80, 1'b0, 2'd2, 2'd2, 400);
        build(1'b1, 80);
        check_model("abc512", 0, 80, 1'b1);
        for (int i = 0; i < 2; i++) check_vec("abc512", v512[i]);
`else
        // 64-bit request is ignored when only the 32-bit datapath is built
        set_abc256();
        push_blk(1'b1, 1'b0);
        run(64, 1'b0, 2'd2, 2'd2, 300);
        build(1'b0, 64);
        check_model("nomacro", 0, 64, 1'b1);
        for (int i = 0; i < 5; i++) check_vec("nomacro", v256[i]);
`endif

        // Backpressure 1,0,0,1
        set_abc256();
        push_blk(1'b1, 1'b0);
        run(64, 1'b1, 2'd0, 2'd0, 600);
        build(1'b0, 64);
        check_model("bp", 0, 64, 1'b1);
        for (int i = 0; i < 5; i++) check_vec("bp", v256[i]);

        // Two-block message
        set_abc256();
        push_blk(1'b0, 1'b0);
        set_blk2();
        push_blk(1'b1, 1'b0);
        run(128, 1'b0, 2'd0, 2'd0, 500);
        set_abc256();
        build(1'b0, 64);
        check_model("blk1", 0, 64, 1'b0);
        set_blk2();
        build(1'b0, 64);
        check_model("blk2", 64, 64, 1'b1);
        if (got_cyc.size() == 128) begin
            check("blk_gap", 64'(got_cyc[64] - got_cyc[63]), 64'd1);
            check("two_blk_span", 64'(got_cyc[127] - got_cyc[0]), 64'd127);
        end

        // Reset mid-expand, then a clean block
        set_abc256();
        push_blk(1'b1, 1'b0);
        run(30, 1'b0, 2'd0, 2'd0, 200);
        reset = 1'b1;
        @(negedge axi_aclk);
        #1;
        reset_checks("mid_rst");
        reset = 1'b0;
        #1;
        check("mid_rst_s_tready", 64'(s_if.tready), 64'd1);
        set_abc256();
        push_blk(1'b1, 1'b0);
        run(64, 1'b0, 2'd0, 2'd0, 300);
        build(1'b0, 64);
        check_model("after_rst", 0, 64, 1'b1);
        for (int i = 0; i < 5; i++) check_vec("after_rst", v256[i]);

        // sha_type flips to 64-bit after the t=0 accept
        set_abc256();
        push_blk(1'b1, 1'b0);
        run(64, 1'b0, 2'd0, 2'd2, 300);
        build(1'b0, 64);
        check_model("mode_chg", 0, 64, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
